mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares a single memory port between the CPU's instruction-fetch requester (ifu) and its load/store requester (lsu).
- Sits between the cpu io_ifu_*/io_lsu_* ports and the one downstream memory/bus port.
- Latches one-cycle request pulses, grants the port by fixed or round-robin priority, holds the grant until the response arrives, then routes the response back.
- A timeout counter converts a hung transaction into an error response.

Parameters:
- LSU_PRIO, 1: 1 = LSU wins ties (fixed priority); 0 = round-robin on ties.
- TIMEOUT, 0: cycles to wait for mem_respValid before aborting; 0 disables the timeout.
- TO_W, 16: width of the timeout counter.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high
- ifu_reqValid  in  1  one-cycle fetch request pulse
- ifu_addr  in  32  fetch address, valid with ifu_reqValid
- ifu_respValid  out  1  fetch response pulse
- ifu_rdata  out  32  fetch data
- lsu_reqValid  in  1  one-cycle load/store request pulse
- lsu_addr  in  32  load/store address
- lsu_size  in  2  access size
- lsu_wen  in  1  1 = store
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  store byte mask
- lsu_respValid  out  1  load/store response pulse
- lsu_rdata  out  32  load data
- mem_reqValid  out  1  one-cycle request pulse to memory
- mem_addr  out  32  request address
- mem_size  out  2  request size
- mem_wen  out  1  request is a store
- mem_wdata  out  32  store data
- mem_wmask  out  4  store byte mask
- mem_respValid  in  1  memory response pulse
- mem_rdata  in  32  memory read data
- timeout_err  out  1  sticky: a transaction timed out
- proto_err  out  1  sticky: a request arrived while that requester already had one pending or in flight

Behaviour:
- Reset (asynchronous): state IDLE; both pending flags 0; last_grant = IFU; timeout counter 0; every output 0.
- Capture: a reqValid pulse sets that requester's pending flag and latches its fields.
  - A pulse while that requester is already pending or in flight sets proto_err and is dropped; the original request is kept.
  - A pulse in the same cycle as that requester's own response is legal and is captured.
- States: IDLE, BUSY_IFU, BUSY_LSU.
- Candidates are the pending flags OR the incoming pulses of the current cycle.
- IDLE: if any candidate exists, pick a winner, go to BUSY_x, and pulse mem_reqValid the next cycle.
  - Latency: request pulse at cycle N gives mem_reqValid at N+1.
- Tie rule:
  - LSU_PRIO=1: LSU wins.
  - LSU_PRIO=0: the requester not equal to last_grant wins.
  - last_grant updates on every grant.
- mem_addr/size/wen/wdata/wmask are registered from the winner's latch and held stable from the mem_reqValid cycle until the response cycle.
- For IFU grants: mem_size = 2'b10, mem_wen = 0, mem_wmask = 0, mem_wdata = 0.
- BUSY_x: wait for mem_respValid.
  - On mem_respValid, in the same cycle (combinational): x_respValid = 1 and x_rdata = mem_rdata.
  - Clear x's pending flag.
  - If the other requester is a candidate, go directly to BUSY_other and pulse mem_reqValid next cycle (no IDLE bubble). Otherwise go to IDLE.
- ifu_rdata/lsu_rdata are only meaningful while the matching respValid is high; drive 0 otherwise.
- mem_respValid in IDLE is ignored; no response pulse is generated.
- Timeout (TIMEOUT>0):
  - The counter clears on grant and increments each BUSY cycle without a response.
  - When it reaches TIMEOUT: pulse x_respValid with x_rdata = 0, set timeout_err, and leave BUSY as on a normal response.
  - A late mem_respValid after the abort is ignored (IDLE rule).
- Reset mid-transaction: everything returns to reset values; an in-flight request is lost.
- Sticky flags clear only on reset.

Decomposition:
- Shared package (arb_pkg): state enum (IDLE/BUSY_IFU/BUSY_LSU), requester-id constants (REQ_IFU=0, REQ_LSU=1), MEM_SIZE_W constant (value 2'b10).
- One sub-module, arb_req_slot: the per-requester pending flag plus field latch, with proto_err detection. It is instantiated twice; the IFU instance ties its unused fields to constants.

Test Plan:
- Single fetch: ifu_reqValid at cycle 2 with addr 0x8000_0000 -> mem_reqValid at cycle 3 with mem_addr 0x8000_0000, mem_wen 0; mem_respValid at cycle 6 with rdata 0x0010_0073 -> ifu_respValid=1, ifu_rdata 0x0010_0073 at cycle 6; lsu_respValid stays 0.
- Simultaneous requests, LSU_PRIO=1: both pulse at cycle 1 (ifu 0x100, lsu store 0x200, wdata 0xDEADBEEF, wmask 0xF) -> LSU issued at cycle 2; after its response, IFU mem_reqValid the next cycle with addr 0x100, with no IDLE cycle between.
- Round robin, LSU_PRIO=0: four back-to-back simultaneous request pairs -> grants alternate, starting with LSU (since last_grant = IFU after reset).
- Protocol error: a second ifu_reqValid (addr 0x104) while 0x100 is in flight -> proto_err=1; the response returns for 0x100 only; only one mem_reqValid is issued.
- Timeout, TIMEOUT=8: fetch granted, no mem_respValid -> ifu_respValid with rdata 0 exactly 8 BUSY cycles after grant; timeout_err=1; a mem_respValid 3 cycles later produces no response.
- Reset while in BUSY_LSU -> all outputs 0 immediately; after release, a new ifu request is served normally.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the ifu/lsu memory-port arbiter.
// The request field bundle is kept as one packed struct so slots and the port register move it as a unit.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2
  } arb_state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_fields_t;

  // Fetches are always word reads, so only the address comes from the requester.
  function automatic req_fields_t ifu_fields(input logic [31:0] addr);
    req_fields_t f;
    f.addr  = addr;
    f.size  = MEM_SIZE_W;
    f.wen   = 1'b0;
    f.wdata = 32'h0;
    f.wmask = 4'h0;
    return f;
  endfunction

endpackage

// File: rtl/arb_req_slot.sv
// One requester's pending flag and field latch. The flag stays set while the request is in flight
// and clears on its response; a pulse arriving in that same response cycle is captured as a new request.
module arb_req_slot
  import arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  req_fields_t req_fields,
  input  logic        done,
  output logic        cand,
  output logic        proto_err,
  output req_fields_t eff_fields
);

  logic        pending_q, pending_d;
  req_fields_t fields_q, fields_d;
  logic        capture;

  always_comb begin
    capture   = req_valid & (~pending_q | done);
    proto_err = req_valid & pending_q & ~done;
    pending_d = pending_q;
    fields_d  = fields_q;
    if (done) pending_d = 1'b0;
    if (capture) begin
      pending_d = 1'b1;
      fields_d  = req_fields;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      fields_q  <= '0;
    end else begin
      pending_q <= pending_d;
      fields_q  <= fields_d;
    end
  end

  // Same-cycle pulses count as candidates, so the arbiter must see the incoming fields too.
  assign cand       = pending_q | req_valid;
  assign eff_fields = fields_d;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Responses are routed back combinationally; a hung transaction is aborted after TIMEOUT busy cycles.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter bit LSU_PRIO = 1'b1,
  parameter int TIMEOUT  = 0,
  parameter int TO_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err,
  output logic        proto_err
);

  localparam bit              TO_EN    = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  arb_state_e      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            mem_req_q, mem_req_d;
  req_fields_t     mem_f_q, mem_f_d;
  logic            terr_q, terr_d;
  logic            perr_q, perr_d;

  logic        ifu_cand, lsu_cand, ifu_perr, lsu_perr;
  logic        ifu_done, lsu_done, abort, finish;
  logic        grant, grant_id, tie_winner;
  req_fields_t ifu_eff, lsu_eff, lsu_in;

  assign lsu_in = {lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask};

  arb_req_slot u_ifu_slot (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (ifu_reqValid),
    .req_fields (ifu_fields(ifu_addr)),
    .done       (ifu_done),
    .cand       (ifu_cand),
    .proto_err  (ifu_perr),
    .eff_fields (ifu_eff)
  );

  arb_req_slot u_lsu_slot (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (lsu_reqValid),
    .req_fields (lsu_in),
    .done       (lsu_done),
    .cand       (lsu_cand),
    .proto_err  (lsu_perr),
    .eff_fields (lsu_eff)
  );

  assign abort      = TO_EN && (to_cnt_q == TO_LIMIT);
  assign finish     = mem_respValid | abort;
  assign ifu_done   = (state_q == BUSY_IFU) & finish;
  assign lsu_done   = (state_q == BUSY_LSU) & finish;
  assign tie_winner = LSU_PRIO ? REQ_LSU : ~last_grant_q;
  assign perr_d     = perr_q | ifu_perr | lsu_perr;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    to_cnt_d      = to_cnt_q;
    mem_req_d     = 1'b0;
    mem_f_d       = mem_f_q;
    terr_d        = terr_q;
    ifu_respValid = 1'b0;
    ifu_rdata     = 32'h0;
    lsu_respValid = 1'b0;
    lsu_rdata     = 32'h0;
    grant         = 1'b0;
    grant_id      = REQ_IFU;

    case (state_q)
      IDLE: begin
        if (ifu_cand | lsu_cand) begin
          grant = 1'b1;
          if (ifu_cand & lsu_cand) grant_id = tie_winner;
          else                     grant_id = lsu_cand ? REQ_LSU : REQ_IFU;
        end
      end
      BUSY_IFU: begin
        if (finish) begin
          ifu_respValid = 1'b1;
          ifu_rdata     = mem_respValid ? mem_rdata : 32'h0;
          if (!mem_respValid) terr_d = 1'b1;
          if (lsu_cand) begin
            grant    = 1'b1;
            grant_id = REQ_LSU;
          end else begin
            state_d = IDLE;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      BUSY_LSU: begin
        if (finish) begin
          lsu_respValid = 1'b1;
          lsu_rdata     = mem_respValid ? mem_rdata : 32'h0;
          if (!mem_respValid) terr_d = 1'b1;
          if (ifu_cand) begin
            grant    = 1'b1;
            grant_id = REQ_IFU;
          end else begin
            state_d = IDLE;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant from any state issues next cycle and restarts the timeout window.
    if (grant) begin
      state_d      = (grant_id == REQ_LSU) ? BUSY_LSU : BUSY_IFU;
      last_grant_d = grant_id;
      to_cnt_d     = '0;
      mem_req_d    = 1'b1;
      mem_f_d      = (grant_id == REQ_LSU) ? lsu_eff : ifu_eff;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_IFU;
      to_cnt_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_f_q      <= '0;
      terr_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      to_cnt_q     <= to_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_f_q      <= mem_f_d;
      terr_q       <= terr_d;
      perr_q       <= perr_d;
    end
  end

  assign mem_reqValid = mem_req_q;
  assign mem_addr     = mem_f_q.addr;
  assign mem_size     = mem_f_q.size;
  assign mem_wen      = mem_f_q.wen;
  assign mem_wdata    = mem_f_q.wdata;
  assign mem_wmask    = mem_f_q.wmask;
  assign timeout_err  = terr_q;
  assign proto_err    = perr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is fixed-priority with TIMEOUT=8, instance 1 is round-robin with TIMEOUT=12.
// Directed scenarios use constant expectations; the random phase compares against a transaction-level model.
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } fld_t;

  logic clock = 1'b0;
  logic reset;

  logic        ifu_req   [2];
  logic [31:0] ifu_addr  [2];
  logic        ifu_rv    [2];
  logic [31:0] ifu_rd    [2];
  logic        lsu_req   [2];
  logic [31:0] lsu_addr  [2];
  logic [1:0]  lsu_size  [2];
  logic        lsu_wen   [2];
  logic [31:0] lsu_wdata [2];
  logic [3:0]  lsu_wmask [2];
  logic        lsu_rv    [2];
  logic [31:0] lsu_rd    [2];
  logic        mem_rv    [2];
  logic [31:0] mem_addr  [2];
  logic [1:0]  mem_size  [2];
  logic        mem_wen   [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wmask [2];
  logic        mresp     [2];
  logic [31:0] mrdata    [2];
  logic        terr_o    [2];
  logic        perr_o    [2];

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .LSU_PRIO ((g == 0) ? 1'b1 : 1'b0),
      .TIMEOUT  ((g == 0) ? 8 : 12),
      .TO_W     (16)
    ) dut (
      .clock         (clock),
      .reset         (reset),
      .ifu_reqValid  (ifu_req[g]),
      .ifu_addr      (ifu_addr[g]),
      .ifu_respValid (ifu_rv[g]),
      .ifu_rdata     (ifu_rd[g]),
      .lsu_reqValid  (lsu_req[g]),
      .lsu_addr      (lsu_addr[g]),
      .lsu_size      (lsu_size[g]),
      .lsu_wen       (lsu_wen[g]),
      .lsu_wdata     (lsu_wdata[g]),
      .lsu_wmask     (lsu_wmask[g]),
      .lsu_respValid (lsu_rv[g]),
      .lsu_rdata     (lsu_rd[g]),
      .mem_reqValid  (mem_rv[g]),
      .mem_addr      (mem_addr[g]),
      .mem_size      (mem_size[g]),
      .mem_wen       (mem_wen[g]),
      .mem_wdata     (mem_wdata[g]),
      .mem_wmask     (mem_wmask[g]),
      .mem_respValid (mresp[g]),
      .mem_rdata     (mrdata[g]),
      .timeout_err   (terr_o[g]),
      .proto_err     (perr_o[g])
    );
  end

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      ifu_req[k] = 1'b0; ifu_addr[k] = 32'h0;
      lsu_req[k] = 1'b0; lsu_addr[k] = 32'h0; lsu_size[k] = 2'b00; lsu_wen[k] = 1'b0;
      lsu_wdata[k] = 32'h0; lsu_wmask[k] = 4'h0;
      mresp[k] = 1'b0; mrdata[k] = 32'h0;
    end
  endtask

  // Advance to the next negedge and drop all one-cycle pulses.
  task automatic cyc();
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      ifu_req[k] = 1'b0; lsu_req[k] = 1'b0; mresp[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mem_rv[k], mem_addr[k], mem_size[k], mem_wen[k], mem_wdata[k], mem_wmask[k],
           ifu_rv[k], ifu_rd[k], lsu_rv[k], lsu_rd[k], terr_o[k], perr_o[k]} !== '0)
        $display("FAIL reset_outputs dut%0d: mem_rv=%0b addr=%h terr=%0b perr=%0b, want all 0",
                 k, mem_rv[k], mem_addr[k], terr_o[k], perr_o[k]);
      else passed++;
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    cyc(); ifu_req[0] = 1'b1; ifu_addr[0] = 32'h8000_0000; #1;
    total++; if (mem_rv[0] !== 1'b0) $display("FAIL fetch_no_early_req: got %0b want 0", mem_rv[0]); else passed++;
    cyc(); #1;
    total++;
    if ({mem_rv[0], mem_addr[0], mem_wen[0], mem_size[0]} !== {1'b1, 32'h8000_0000, 1'b0, 2'b10})
      $display("FAIL fetch_issue: rv=%0b addr=%h wen=%0b size=%0d want 1 80000000 0 2",
               mem_rv[0], mem_addr[0], mem_wen[0], mem_size[0]);
    else passed++;
    repeat (2) cyc();
    cyc(); mresp[0] = 1'b1; mrdata[0] = 32'h0010_0073; #1;
    total++;
    if ({ifu_rv[0], ifu_rd[0], lsu_rv[0]} !== {1'b1, 32'h0010_0073, 1'b0})
      $display("FAIL fetch_resp: ifu_rv=%0b rdata=%h lsu_rv=%0b want 1 00100073 0", ifu_rv[0], ifu_rd[0], lsu_rv[0]);
    else passed++;
    cyc(); #1;
    total++;
    if ({ifu_rv[0], ifu_rd[0]} !== {1'b0, 32'h0})
      $display("FAIL fetch_resp_clear: ifu_rv=%0b rdata=%h want 0 0", ifu_rv[0], ifu_rd[0]);
    else passed++;
  endtask

  task automatic test_simultaneous();
    cyc();
    ifu_req[0] = 1'b1; ifu_addr[0] = 32'h100;
    lsu_req[0] = 1'b1; lsu_addr[0] = 32'h200; lsu_size[0] = 2'b10; lsu_wen[0] = 1'b1;
    lsu_wdata[0] = 32'hDEAD_BEEF; lsu_wmask[0] = 4'hF;
    cyc(); #1;
    total++;
    if ({mem_rv[0], mem_addr[0], mem_wen[0], mem_wdata[0], mem_wmask[0]} !== {1'b1, 32'h200, 1'b1, 32'hDEAD_BEEF, 4'hF})
      $display("FAIL prio_lsu_first: rv=%0b addr=%h wen=%0b wdata=%h wmask=%h want 1 200 1 deadbeef f",
               mem_rv[0], mem_addr[0], mem_wen[0], mem_wdata[0], mem_wmask[0]);
    else passed++;
    cyc();
    cyc(); mresp[0] = 1'b1; mrdata[0] = 32'h1234_5678; #1;
    total++;
    if ({lsu_rv[0], lsu_rd[0], ifu_rv[0], mem_addr[0]} !== {1'b1, 32'h1234_5678, 1'b0, 32'h200})
      $display("FAIL prio_lsu_resp: lsu_rv=%0b rdata=%h ifu_rv=%0b addr=%h want 1 12345678 0 200",
               lsu_rv[0], lsu_rd[0], ifu_rv[0], mem_addr[0]);
    else passed++;
    cyc(); #1;
    total++;
    if ({mem_rv[0], mem_addr[0], mem_size[0], mem_wen[0], mem_wdata[0], mem_wmask[0]} !== {1'b1, 32'h100, 2'b10, 1'b0, 32'h0, 4'h0})
      $display("FAIL prio_ifu_no_bubble: rv=%0b addr=%h wen=%0b wdata=%h wmask=%h want 1 100 0 0 0",
               mem_rv[0], mem_addr[0], mem_wen[0], mem_wdata[0], mem_wmask[0]);
    else passed++;
    cyc(); mresp[0] = 1'b1; mrdata[0] = 32'h0000_0013; #1;
    total++;
    if ({ifu_rv[0], ifu_rd[0], lsu_rv[0]} !== {1'b1, 32'h13, 1'b0})
      $display("FAIL prio_ifu_resp: ifu_rv=%0b rdata=%h lsu_rv=%0b want 1 13 0", ifu_rv[0], ifu_rd[0], lsu_rv[0]);
    else passed++;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      cyc();
      ifu_req[1] = 1'b1; ifu_addr[1] = 32'h1000 + 32'(i * 8);
      lsu_req[1] = 1'b1; lsu_addr[1] = 32'h2000 + 32'(i * 8); lsu_size[1] = 2'b10; lsu_wen[1] = 1'b0;
      cyc(); #1;
      total++;
      if ({mem_rv[1], mem_addr[1]} !== {1'b1, 32'h2000 + 32'(i * 8)})
        $display("FAIL rr_pair%0d_lsu_grant: rv=%0b addr=%h want 1 %h", i, mem_rv[1], mem_addr[1], 32'h2000 + 32'(i * 8));
      else passed++;
      cyc(); mresp[1] = 1'b1; mrdata[1] = 32'(i);
      cyc(); #1;
      total++;
      if ({mem_rv[1], mem_addr[1]} !== {1'b1, 32'h1000 + 32'(i * 8)})
        $display("FAIL rr_pair%0d_ifu_grant: rv=%0b addr=%h want 1 %h", i, mem_rv[1], mem_addr[1], 32'h1000 + 32'(i * 8));
      else passed++;
      cyc(); mresp[1] = 1'b1; mrdata[1] = 32'(i + 100); #1;
      total++;
      if ({ifu_rv[1], ifu_rd[1]} !== {1'b1, 32'(i + 100)})
        $display("FAIL rr_pair%0d_ifu_resp: rv=%0b rdata=%h want 1 %h", i, ifu_rv[1], ifu_rd[1], 32'(i + 100));
      else passed++;
    end
    // After a lone LSU grant, the next tie must go to IFU.
    cyc(); lsu_req[1] = 1'b1; lsu_addr[1] = 32'h3000;
    cyc();
    cyc(); mresp[1] = 1'b1;
    cyc(); ifu_req[1] = 1'b1; ifu_addr[1] = 32'h3100; lsu_req[1] = 1'b1; lsu_addr[1] = 32'h3200;
    cyc(); #1;
    total++;
    if ({mem_rv[1], mem_addr[1]} !== {1'b1, 32'h3100})
      $display("FAIL rr_tie_after_lsu: rv=%0b addr=%h want 1 3100", mem_rv[1], mem_addr[1]);
    else passed++;
    cyc(); mresp[1] = 1'b1;
    cyc(); #1;
    total++;
    if ({mem_rv[1], mem_addr[1]} !== {1'b1, 32'h3200})
      $display("FAIL rr_tie_loser: rv=%0b addr=%h want 1 3200", mem_rv[1], mem_addr[1]);
    else passed++;
    cyc(); mresp[1] = 1'b1;
  endtask

  task automatic test_proto_err();
    int issues;
    cyc(); #1;
    total++; if (perr_o[0] !== 1'b0) $display("FAIL proto_clean_before: got %0b want 0", perr_o[0]); else passed++;
    cyc(); ifu_req[0] = 1'b1; ifu_addr[0] = 32'h100;
    cyc(); ifu_req[0] = 1'b1; ifu_addr[0] = 32'h104;
    cyc(); #1;
    total++; if (perr_o[0] !== 1'b1) $display("FAIL proto_err_set: got %0b want 1", perr_o[0]); else passed++;
    cyc(); mresp[0] = 1'b1; mrdata[0] = 32'hCAFE_0100; #1;
    total++;
    if ({ifu_rv[0], ifu_rd[0], mem_addr[0]} !== {1'b1, 32'hCAFE_0100, 32'h100})
      $display("FAIL proto_resp_orig: rv=%0b rdata=%h addr=%h want 1 cafe0100 100", ifu_rv[0], ifu_rd[0], mem_addr[0]);
    else passed++;
    issues = 0;
    repeat (5) begin
      cyc(); #1;
      if (mem_rv[0] === 1'b1) issues++;
    end
    total++; if (issues !== 0) $display("FAIL proto_dropped: extra issues %0d want 0", issues); else passed++;
  endtask

  task automatic test_timeout();
    int early;
    cyc(); ifu_req[0] = 1'b1; ifu_addr[0] = 32'h300;
    cyc(); #1;
    total++; if (mem_rv[0] !== 1'b1) $display("FAIL to_issue: got %0b want 1", mem_rv[0]); else passed++;
    early = 0;
    for (int i = 1; i < 8; i++) begin
      cyc(); #1;
      if (ifu_rv[0] === 1'b1 || terr_o[0] === 1'b1) early++;
    end
    total++; if (early !== 0) $display("FAIL to_early_abort: %0d early cycles want 0", early); else passed++;
    cyc(); #1;
    total++;
    if ({ifu_rv[0], ifu_rd[0]} !== {1'b1, 32'h0})
      $display("FAIL to_abort_resp: rv=%0b rdata=%h want 1 0", ifu_rv[0], ifu_rd[0]);
    else passed++;
    cyc(); #1;
    total++;
    if ({terr_o[0], ifu_rv[0]} !== 2'b10)
      $display("FAIL to_err_sticky: terr=%0b rv=%0b want 1 0", terr_o[0], ifu_rv[0]);
    else passed++;
    cyc(); cyc(); mresp[0] = 1'b1; mrdata[0] = 32'hABCD; #1;
    total++;
    if ({ifu_rv[0], lsu_rv[0], mem_rv[0]} !== 3'b000)
      $display("FAIL to_late_resp_ignored: ifu_rv=%0b lsu_rv=%0b mem_rv=%0b want 0 0 0", ifu_rv[0], lsu_rv[0], mem_rv[0]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    cyc(); lsu_req[0] = 1'b1; lsu_addr[0] = 32'h500; lsu_wen[0] = 1'b1; lsu_wdata[0] = 32'h77; lsu_wmask[0] = 4'h3;
    cyc(); #1;
    total++; if (mem_rv[0] !== 1'b1) $display("FAIL rst_mid_issue: got %0b want 1", mem_rv[0]); else passed++;
    cyc(); reset = 1'b1; mresp[0] = 1'b1; mrdata[0] = 32'h99; #1;
    total++;
    if ({lsu_rv[0], lsu_rd[0], mem_rv[0], mem_addr[0], mem_wen[0], mem_wdata[0], terr_o[0], perr_o[0]} !== '0)
      $display("FAIL rst_mid_outputs: lsu_rv=%0b addr=%h wen=%0b terr=%0b perr=%0b want all 0",
               lsu_rv[0], mem_addr[0], mem_wen[0], terr_o[0], perr_o[0]);
    else passed++;
    cyc(); reset = 1'b0;
    cyc(); ifu_req[0] = 1'b1; ifu_addr[0] = 32'h400;
    cyc(); #1;
    total++;
    if ({mem_rv[0], mem_addr[0], mem_wen[0]} !== {1'b1, 32'h400, 1'b0})
      $display("FAIL rst_mid_new_issue: rv=%0b addr=%h wen=%0b want 1 400 0", mem_rv[0], mem_addr[0], mem_wen[0]);
    else passed++;
    cyc(); mresp[0] = 1'b1; mrdata[0] = 32'h55; #1;
    total++;
    if ({ifu_rv[0], ifu_rd[0], lsu_rv[0]} !== {1'b1, 32'h55, 1'b0})
      $display("FAIL rst_mid_new_resp: ifu_rv=%0b rdata=%h lsu_rv=%0b want 1 55 0", ifu_rv[0], ifu_rd[0], lsu_rv[0]);
    else passed++;
  endtask

  // Transaction-level reference: who owns the port, what each requester has outstanding, and the issued fields.
  task automatic test_random();
    int   owner [2];
    int   last  [2];
    int   cnt   [2];
    bit   pend  [2][2];
    fld_t fld   [2][2];
    fld_t cur   [2];
    bit   exp_req [2];
    bit   terr  [2];
    bit   perr  [2];
    bit   rq    [2][2];
    fld_t in_f  [2][2];

    @(negedge clock); reset = 1'b1; idle_inputs();
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; last[k] = 0; cnt[k] = 0; exp_req[k] = 1'b0; terr[k] = 1'b0; perr[k] = 1'b0;
      pend[k][0] = 1'b0; pend[k][1] = 1'b0; cur[k] = '0;
    end

    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        rq[k][0] = ($urandom_range(3) == 0);
        rq[k][1] = ($urandom_range(3) == 0);
        in_f[k][0] = {32'($urandom), 2'b10, 1'b0, 32'h0, 4'h0};
        in_f[k][1] = {32'($urandom), 2'($urandom), 1'($urandom), 32'($urandom), 4'($urandom)};
        ifu_req[k] = rq[k][0]; ifu_addr[k] = in_f[k][0].addr;
        lsu_req[k] = rq[k][1]; lsu_addr[k] = in_f[k][1].addr; lsu_size[k] = in_f[k][1].size;
        lsu_wen[k] = in_f[k][1].wen; lsu_wdata[k] = in_f[k][1].wdata; lsu_wmask[k] = in_f[k][1].wmask;
        mresp[k] = ($urandom_range(3) == 0); mrdata[k] = $urandom;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        bit          fin;
        bit          prio;
        int          tmo;
        int          w;
        logic [31:0] rd;
        prio = (k == 0);
        tmo  = (k == 0) ? 8 : 12;
        fin  = 1'b0;
        rd   = 32'h0;
        if (owner[k] >= 0) begin
          fin = mresp[k] || (cnt[k] == tmo);
          if (mresp[k]) rd = mrdata[k];
        end

        total++;
        if (mem_rv[k] !== exp_req[k])
          $display("FAIL rnd_mem_req dut%0d cyc%0d: got %0b want %0b", k, n, mem_rv[k], exp_req[k]);
        else passed++;
        if (owner[k] >= 0) begin
          total++;
          if ({mem_addr[k], mem_size[k], mem_wen[k], mem_wdata[k], mem_wmask[k]} !== cur[k])
            $display("FAIL rnd_mem_fields dut%0d cyc%0d: got %h want %h", k, n,
                     {mem_addr[k], mem_size[k], mem_wen[k], mem_wdata[k], mem_wmask[k]}, cur[k]);
          else passed++;
        end
        total++;
        if ({ifu_rv[k], ifu_rd[k]} !== {fin && owner[k] == 0, (fin && owner[k] == 0) ? rd : 32'h0})
          $display("FAIL rnd_ifu_resp dut%0d cyc%0d: got %0b/%h want %0b/%h", k, n, ifu_rv[k], ifu_rd[k],
                   fin && owner[k] == 0, (fin && owner[k] == 0) ? rd : 32'h0);
        else passed++;
        total++;
        if ({lsu_rv[k], lsu_rd[k]} !== {fin && owner[k] == 1, (fin && owner[k] == 1) ? rd : 32'h0})
          $display("FAIL rnd_lsu_resp dut%0d cyc%0d: got %0b/%h want %0b/%h", k, n, lsu_rv[k], lsu_rd[k],
                   fin && owner[k] == 1, (fin && owner[k] == 1) ? rd : 32'h0);
        else passed++;
        total++;
        if ({terr_o[k], perr_o[k]} !== {terr[k], perr[k]})
          $display("FAIL rnd_sticky dut%0d cyc%0d: got terr=%0b perr=%0b want %0b %0b", k, n,
                   terr_o[k], perr_o[k], terr[k], perr[k]);
        else passed++;

        if (fin && !mresp[k]) terr[k] = 1'b1;
        if (fin) pend[k][owner[k]] = 1'b0;
        for (int r = 0; r < 2; r++) begin
          if (rq[k][r]) begin
            if (pend[k][r]) perr[k] = 1'b1;
            else begin
              pend[k][r] = 1'b1;
              fld[k][r]  = in_f[k][r];
            end
          end
        end
        w = -1;
        if (owner[k] >= 0) begin
          if (fin) begin
            if (pend[k][1 - owner[k]]) w = 1 - owner[k];
            else owner[k] = -1;
          end else begin
            cnt[k]++;
          end
        end else if (pend[k][0] || pend[k][1]) begin
          if (pend[k][0] && pend[k][1]) w = prio ? 1 : 1 - last[k];
          else w = pend[k][1] ? 1 : 0;
        end
        exp_req[k] = (w >= 0);
        if (w >= 0) begin
          owner[k] = w; last[k] = w; cnt[k] = 0; cur[k] = fld[k][w];
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_round_robin();
    test_proto_err();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", passed, total);
    $fatal(1);
  end

endmodule
